// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
//   state_t      : detector FSM states
//   DEF_MAX_LEN  : default maximum pattern length
//   DEF_CNT_W    : default match counter width
//   cfg_len_ok() : legality check for a loaded pattern length
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 8;

  // S_IDLE : no usable pattern loaded (after reset or an illegal load)
  // S_FILL : fewer than len_q bits received since load / last non-overlapped match
  // S_ARMED: enough history to compare against the full pattern
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  // A pattern length is usable when it is 1..max_len inclusive.
  function automatic logic cfg_len_ok(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// Combinational masked comparator for the serial-pattern detector.
// Ports:
//   i_hist  [MAX_LEN-1:0] : shift history, bit 0 is the most recent bit
//   i_pat   [MAX_LEN-1:0] : pattern, bit 0 is the last bit of the pattern
//   i_len   [LEN_W-1:0]   : number of low bits that take part in the compare
//   o_match               : 1 when the low i_len bits of i_hist equal i_pat
module seq_det_match #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] i_hist,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_match
);

  localparam logic [MAX_LEN:0] ONE = {{MAX_LEN{1'b0}}, 1'b1};

  logic [MAX_LEN:0] w_mask;
  logic [MAX_LEN:0] w_diff;

  // The mask is one bit wider than the history so that len==MAX_LEN
  // yields an all-ones compare window instead of wrapping to zero.
  always_comb begin
    w_mask  = (ONE << i_len) - ONE;
    w_diff  = {1'b0, i_hist ^ i_pat} & w_mask;
    o_match = (w_diff == '0);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with runtime-loadable pattern.
// Ports:
//   clk        : clock, all state on rising edge
//   clr        : asynchronous active-high reset
//   en         : sample enable, `in` is consumed only when en=1
//   in         : serial data bit
//   load       : latch pattern/len/overlap into shadow registers
//   pattern    : pattern, pattern[len-1] is the first bit received
//   len        : pattern length (1..MAX_LEN legal)
//   overlap    : 1 = overlapping detection, 0 = non-overlapping
//   out        : registered match flag, high for one cycle after the final bit
//   match_cnt  : saturating count of matches since last clr/load
//   cfg_err    : last loaded length was illegal
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic               in,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  // Shadow configuration
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_cfg_err;

  // Datapath state
  state_t             r_state;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_out;
  logic [CNT_W-1:0]   r_cnt;

  // Next-state values
  state_t             w_state_nxt;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic               w_out_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Helpers
  logic [MAX_LEN-1:0] w_hist_shift;
  logic [LEN_W:0]     w_fill_inc;
  logic [LEN_W-1:0]   w_fill_sat;
  logic               w_len_reached;
  logic               w_cmp;
  logic               w_hit;
  logic               w_cfg_ok;

  // History as it will look once the current bit is shifted in; the match
  // decision is taken on this value so out rises right after the final bit.
  assign w_hist_shift = {r_hist[MAX_LEN-2:0], in};

  seq_det_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .i_hist  (w_hist_shift),
    .i_pat   (r_pat),
    .i_len   (r_len),
    .o_match (w_cmp)
  );

  always_comb begin
    w_cfg_ok      = cfg_len_ok(32'(len), MAX_LEN);
    // fill+1 is formed one bit wider so the MAX_LEN saturation test is exact
    w_fill_inc    = {1'b0, r_fill} + (LEN_W + 1)'(1);
    w_fill_sat    = (w_fill_inc > (LEN_W + 1)'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                         : w_fill_inc[LEN_W-1:0];
    w_len_reached = (w_fill_inc >= {1'b0, r_len});
    w_hit         = w_len_reached && w_cmp;
  end

  // FSM state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode; load overrides sampling
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_out_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;

    if (load) begin
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = w_cfg_ok ? S_FILL : S_IDLE;
    end else if (en) begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_FILL, S_ARMED: begin
          w_hist_nxt = w_hist_shift;
          w_fill_nxt = w_fill_sat;
          if (w_hit) begin
            w_out_nxt = 1'b1;
            w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
            if (r_ovl) begin
              w_state_nxt = S_ARMED;
            end else begin
              // Non-overlapping: the next match must be built from fresh bits
              w_fill_nxt  = '0;
              w_state_nxt = S_FILL;
            end
          end else begin
            w_state_nxt = w_len_reached ? S_ARMED : S_FILL;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Datapath and shadow configuration registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_ovl     <= 1'b0;
      r_cfg_err <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_out     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (load) begin
        r_pat     <= pattern;
        r_len     <= len;
        r_ovl     <= overlap;
        r_cfg_err <= ~w_cfg_ok;
      end
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_out  <= w_out_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign out       = r_out;
  assign match_cnt = r_cnt;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed vector table,
// hand-written corner sequences and randomized traffic against a
// queue-based reference model. A second instance with a 2-bit counter
// shares all inputs to exercise counter saturation.
module tb_seq_detector_param;

  logic       clk;
  logic       clr;
  logic       en;
  logic       d_in;
  logic       ld;
  logic [7:0] pat;
  logic [3:0] len;
  logic       ovl;
  logic       dout;
  logic [7:0] cnt;
  logic       err;
  logic       dout2;
  logic [1:0] cnt2;
  logic       err2;

  int total = 0;
  int bad   = 0;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .en(en), .in(d_in), .load(ld), .pattern(pat),
    .len(len), .overlap(ovl), .out(dout), .match_cnt(cnt), .cfg_err(err)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .en(en), .in(d_in), .load(ld), .pattern(pat),
    .len(len), .overlap(ovl), .out(dout2), .match_cnt(cnt2), .cfg_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         m_valid;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_out;
  bit         m_err;
  int         m_cnt;
  int         m_cnt2;
  bit         m_bits[$];   // bits received since load / last non-overlapped match

  function automatic void model_reset();
    m_valid = 0; m_pat = '0; m_len = 0; m_ovl = 0;
    m_out = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
    m_bits.delete();
  endfunction

  function automatic void model_step(bit l, bit e, bit d, logic [7:0] p, logic [3:0] n, bit o);
    bit hit;
    int sz;
    if (l) begin
      m_pat = p; m_len = int'(n); m_ovl = o;
      m_valid = (m_len >= 1) && (m_len <= 8);
      m_err = !m_valid;
      m_bits.delete();
      m_cnt = 0; m_cnt2 = 0; m_out = 0;
    end else if (e && m_valid) begin
      m_bits.push_back(d);
      if (m_bits.size() > 16) void'(m_bits.pop_front());
      sz  = m_bits.size();
      hit = (sz >= m_len);
      // most recent m_len bits, oldest first, against pattern MSB-first
      if (hit)
        for (int k = 0; k < m_len; k++)
          if (m_bits[sz - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
      m_out = hit;
      if (hit) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
        if (!m_ovl) m_bits.delete();
      end
    end else begin
      m_out = 0;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("mdl_out",  int'(dout),  int'(m_out));
    chk("mdl_cnt",  int'(cnt),   m_cnt);
    chk("mdl_err",  int'(err),   int'(m_err));
    chk("mdl_out2", int'(dout2), int'(m_out));
    chk("mdl_cnt2", int'(cnt2),  m_cnt2);
    chk("mdl_err2", int'(err2),  int'(m_err));
  endtask

  // Drive one cycle, advance the model, sample 1 ns after the edge.
  task automatic apply(input bit l, input bit e, input bit d,
                       input logic [7:0] p, input logic [3:0] n, input bit o);
    ld = l; en = e; d_in = d; pat = p; len = n; ovl = o;
    model_step(l, e, d, p, n, o);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic bit_in(input bit d);
    apply(0, 1, d, pat, len, ovl);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         ld;
    bit         en;
    bit         d;
    logic [7:0] pat;
    logic [3:0] len;
    bit         ovl;
    bit         x_out;
    int         x_cnt;
    bit         x_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit l, bit e, bit d, logic [7:0] p, logic [3:0] n, bit o,
                              bit xo, int xc, bit xe);
    vec_t v;
    v.ld = l; v.en = e; v.d = d; v.pat = p; v.len = n; v.ovl = o;
    v.x_out = xo; v.x_cnt = xc; v.x_err = xe;
    return v;
  endfunction

  initial begin
    // overlapping 101: pulses after bits 3 and 5
    tbl.push_back(mk(1,0,0, 8'b101,3,1, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'b101,3,1, 0,0,0));
    tbl.push_back(mk(0,1,0, 8'b101,3,1, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'b101,3,1, 1,1,0));
    tbl.push_back(mk(0,1,0, 8'b101,3,1, 0,1,0));
    tbl.push_back(mk(0,1,1, 8'b101,3,1, 1,2,0));
    // non-overlapping 101: only one pulse
    tbl.push_back(mk(1,0,0, 8'b101,3,0, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'b101,3,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 8'b101,3,0, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'b101,3,0, 1,1,0));
    tbl.push_back(mk(0,1,0, 8'b101,3,0, 0,1,0));
    tbl.push_back(mk(0,1,1, 8'b101,3,0, 0,1,0));
    // 1001 with en gaps
    tbl.push_back(mk(1,0,0, 8'b1001,4,1, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'b1001,4,1, 0,0,0));
    tbl.push_back(mk(0,1,0, 8'b1001,4,1, 0,0,0));
    tbl.push_back(mk(0,0,1, 8'b1001,4,1, 0,0,0));
    tbl.push_back(mk(0,0,1, 8'b1001,4,1, 0,0,0));
    tbl.push_back(mk(0,0,1, 8'b1001,4,1, 0,0,0));
    tbl.push_back(mk(0,1,0, 8'b1001,4,1, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'b1001,4,1, 1,1,0));
    tbl.push_back(mk(0,0,1, 8'b1001,4,1, 0,1,0));
    // full-length pattern 10110011 (len == MAX_LEN)
    tbl.push_back(mk(1,0,0, 8'hB3,8,1, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'hB3,8,1, 0,0,0));
    tbl.push_back(mk(0,1,0, 8'hB3,8,1, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'hB3,8,1, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'hB3,8,1, 0,0,0));
    tbl.push_back(mk(0,1,0, 8'hB3,8,1, 0,0,0));
    tbl.push_back(mk(0,1,0, 8'hB3,8,1, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'hB3,8,1, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'hB3,8,1, 1,1,0));
    // illegal lengths
    tbl.push_back(mk(1,0,0, 8'hFF,0,1, 0,0,1));
    tbl.push_back(mk(0,1,1, 8'hFF,0,1, 0,0,1));
    tbl.push_back(mk(0,1,1, 8'hFF,0,1, 0,0,1));
    tbl.push_back(mk(1,0,0, 8'hFF,9,1, 0,0,1));
    tbl.push_back(mk(0,1,1, 8'hFF,9,1, 0,0,1));
  end

  // ---------------- main sequence ----------------
  initial begin
    clr = 1'b1; en = 0; d_in = 0; ld = 0; pat = '0; len = '0; ovl = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", int'(dout), 0);
    chk("rst_cnt", int'(cnt),  0);
    chk("rst_err", int'(err),  0);
    clr = 1'b0;

    // directed table
    for (int i = 0; i < int'(tbl.size()); i++) begin
      apply(tbl[i].ld, tbl[i].en, tbl[i].d, tbl[i].pat, tbl[i].len, tbl[i].ovl);
      chk($sformatf("tbl%0d_out", i), int'(dout), int'(tbl[i].x_out));
      chk($sformatf("tbl%0d_cnt", i), int'(cnt),  tbl[i].x_cnt);
      chk($sformatf("tbl%0d_err", i), int'(err),  int'(tbl[i].x_err));
    end

    // illegal config stays idle over a long run of ones
    for (int i = 0; i < 20; i++) begin
      bit_in(1);
      chk("idle_out", int'(dout), 0);
      chk("idle_cnt", int'(cnt),  0);
    end

    // len=1: every matching bit pulses; 2-bit counter saturates at 3
    apply(1, 0, 0, 8'h01, 4'd1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      bit_in(1);
      chk("len1_out",  int'(dout2), 1);
      chk("len1_cnt2", int'(cnt2),  (k + 1 < 3) ? k + 1 : 3);
      chk("len1_cnt",  int'(cnt),   k + 1);
    end

    // load on a would-be match edge: load wins, nothing counted
    apply(1, 0, 0, 8'b11, 4'd2, 1'b1);
    bit_in(1);
    apply(1, 1, 1, 8'b11, 4'd2, 1'b1);
    chk("ldm_out", int'(dout), 0);
    chk("ldm_cnt", int'(cnt),  0);
    bit_in(1);
    chk("ldm_fresh_out", int'(dout), 0);
    bit_in(1);
    chk("ldm_match_out", int'(dout), 1);
    chk("ldm_match_cnt", int'(cnt),  1);

    // clr mid-stream after a match and a partial pattern
    apply(1, 0, 0, 8'b101, 4'd3, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0);
    chk("pre_clr_cnt", int'(cnt), 1);
    clr = 1'b1;
    model_reset();
    #2;
    chk("clr_out",  int'(dout), 0);
    chk("clr_cnt",  int'(cnt),  0);
    chk("clr_err",  int'(err),  0);
    chk("clr_cnt2", int'(cnt2), 0);
    clr = 1'b0;
    bit_in(1); bit_in(0); bit_in(1);
    chk("post_clr_idle", int'(dout), 0);
    apply(1, 0, 0, 8'b101, 4'd3, 1'b1);
    bit_in(1);
    chk("reload_b1", int'(dout), 0);
    bit_in(0);
    chk("reload_b2", int'(dout), 0);
    bit_in(1);
    chk("reload_b3", int'(dout), 1);
    chk("reload_cnt", int'(cnt), 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit         l, e, d, o;
      logic [7:0] p;
      logic [3:0] n;
      l = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 4) != 0);
      d = 1'($urandom);
      o = 1'($urandom);
      p = 8'($urandom);
      n = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(1, 3));
      if (l) apply(1, e, d, p, n, o);
      else   apply(0, e, d, pat, len, ovl);
      if ($urandom_range(0, 299) == 0) begin
        clr = 1'b1;
        model_reset();
        #2;
        check_model();
        clr = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
